// File: rtl/rv_dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, grant IDs,
// the registered memory command and the round-robin pick helper.
package rv_dm_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_BUSY_C = 2'd1;
    localparam logic [1:0] ST_BUSY_A = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic GRANT_CORE = 1'b0;
    localparam logic GRANT_AUX  = 1'b1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  bwe;
    } mem_cmd_t;

    // Lone requester wins outright; on a tie the one not served last wins.
    function automatic logic rr_pick(input logic c_req, input logic a_req,
                                     input logic last_grant);
        if (c_req && a_req)
            return ~last_grant;
        else if (c_req)
            return GRANT_CORE;
        else
            return GRANT_AUX;
    endfunction

endpackage

// File: rtl/rv_dm_arbiter_if.sv
// Bus bundle for rv_dm_arbiter: core and aux requester sides plus the memory side.
interface rv_dm_arbiter_if;

    logic        c_req_i;
    logic        c_we_i;
    logic [31:0] c_addr_i;
    logic [31:0] c_data_s_i;
    logic [3:0]  c_bwe_i;
    logic        c_load_done_o;
    logic        c_store_done_o;
    logic [31:0] c_data_l_o;

    logic        a_req_i;
    logic        a_we_i;
    logic [31:0] a_addr_i;
    logic [31:0] a_data_i;
    logic [3:0]  a_bwe_i;
    logic        a_ack_o;
    logic [31:0] a_data_o;

    logic        m_req_o;
    logic        m_we_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic [3:0]  m_bwe_o;
    logic        m_ack_i;
    logic [31:0] m_data_i;

    logic        err_o;

    // Arbiter view: it masters the memory bus.
    modport master (
        input  c_req_i, c_we_i, c_addr_i, c_data_s_i, c_bwe_i,
        output c_load_done_o, c_store_done_o, c_data_l_o,
        input  a_req_i, a_we_i, a_addr_i, a_data_i, a_bwe_i,
        output a_ack_o, a_data_o,
        output m_req_o, m_we_o, m_addr_o, m_data_o, m_bwe_o,
        input  m_ack_i, m_data_i,
        output err_o
    );

    // Environment view: requesters and memory.
    modport slave (
        output c_req_i, c_we_i, c_addr_i, c_data_s_i, c_bwe_i,
        input  c_load_done_o, c_store_done_o, c_data_l_o,
        output a_req_i, a_we_i, a_addr_i, a_data_i, a_bwe_i,
        input  a_ack_o, a_data_o,
        input  m_req_o, m_we_o, m_addr_o, m_data_o, m_bwe_o,
        output m_ack_i, m_data_i,
        input  err_o
    );

endinterface

// File: rtl/rv_dm_arbiter_timeout.sv
// Ack-wait counter for rv_dm_arbiter: cleared on grant, counts BUSY cycles
// without ack, flags expiry on the TIMEOUT_CYCLES-th such cycle.
module rv_dm_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic busy_i,
    input  logic ack_i,
    output logic expired_o
);

    localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt <= '0;
        else if (clr_i)
            cnt <= '0;
        else if (busy_i && !ack_i)
            cnt <= cnt + 1'b1;
    end

    // An ack on the expiry cycle takes precedence.
    assign expired_o = busy_i && !ack_i && (cnt == LAST);

endmodule

// File: rtl/rv_dm_arbiter.sv
// Round-robin data-memory arbiter between core load/store and aux master.
// Optional ack timeout enabled by defining RV_DM_TIMEOUT_EN.
module rv_dm_arbiter
    import rv_dm_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_DATA       = 32'hdeadbeef
) (
    input  logic            clk_i,
    input  logic            rst_i,
    rv_dm_arbiter_if.master bus
);

    logic [1:0]  state;
    logic        last_grant;
    logic        owner;
    logic        we_lat;
    logic        err_lat;
    logic        m_req, m_we;
    logic [31:0] m_addr, m_data;
    logic [3:0]  m_bwe;
    logic [31:0] c_data_l, a_data;

    logic        any_req;
    logic        grant;
    mem_cmd_t    core_cmd, aux_cmd, sel_cmd;
    logic        busy;
    logic        expired;

    always_comb begin
        any_req  = bus.c_req_i || bus.a_req_i;
        grant    = rr_pick(bus.c_req_i, bus.a_req_i, last_grant);
        core_cmd = '{we: bus.c_we_i, addr: bus.c_addr_i, data: bus.c_data_s_i, bwe: bus.c_bwe_i};
        aux_cmd  = '{we: bus.a_we_i, addr: bus.a_addr_i, data: bus.a_data_i, bwe: bus.a_bwe_i};
        sel_cmd  = (grant == GRANT_AUX) ? aux_cmd : core_cmd;
        busy     = (state == ST_BUSY_C) || (state == ST_BUSY_A);
    end

`ifdef RV_DM_TIMEOUT_EN
    rv_dm_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     ((state == ST_IDLE) && any_req),
        .busy_i    (busy),
        .ack_i     (bus.m_ack_i),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= ST_IDLE;
            last_grant <= GRANT_AUX;
            owner      <= GRANT_CORE;
            we_lat     <= 1'b0;
            err_lat    <= 1'b0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_data     <= '0;
            m_bwe      <= '0;
            c_data_l   <= '0;
            a_data     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        m_req      <= 1'b1;
                        m_we       <= sel_cmd.we;
                        m_addr     <= sel_cmd.addr;
                        m_data     <= sel_cmd.data;
                        m_bwe      <= sel_cmd.bwe;
                        we_lat     <= sel_cmd.we;
                        err_lat    <= 1'b0;
                        last_grant <= grant;
                        owner      <= grant;
                        state      <= (grant == GRANT_AUX) ? ST_BUSY_A : ST_BUSY_C;
                    end
                end
                ST_BUSY_C, ST_BUSY_A: begin
                    if (bus.m_ack_i || expired) begin
                        if (!we_lat) begin
                            if (owner == GRANT_AUX)
                                a_data <= bus.m_ack_i ? bus.m_data_i : ERR_DATA;
                            else
                                c_data_l <= bus.m_ack_i ? bus.m_data_i : ERR_DATA;
                        end
                        err_lat <= !bus.m_ack_i;
                        m_req   <= 1'b0;
                        m_we    <= 1'b0;
                        state   <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Done pulses decode the DONE state, so only one owner can ever be flagged.
    assign bus.c_load_done_o  = (state == ST_DONE) && (owner == GRANT_CORE) && !we_lat;
    assign bus.c_store_done_o = (state == ST_DONE) && (owner == GRANT_CORE) &&  we_lat;
    assign bus.a_ack_o        = (state == ST_DONE) && (owner == GRANT_AUX);
    assign bus.err_o          = (state == ST_DONE) && err_lat;
    assign bus.c_data_l_o     = c_data_l;
    assign bus.a_data_o       = a_data;
    assign bus.m_req_o        = m_req;
    assign bus.m_we_o         = m_we;
    assign bus.m_addr_o       = m_addr;
    assign bus.m_data_o       = m_data;
    assign bus.m_bwe_o        = m_bwe;

endmodule

// File: tb/tb_rv_dm_arbiter.sv
// Directed self-checking bench for rv_dm_arbiter; timeout cases run only
// when RV_DM_TIMEOUT_EN is defined.
module tb_rv_dm_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    rv_dm_arbiter_if bus();

    rv_dm_arbiter #(
        .TIMEOUT_CYCLES(16),
        .ERR_DATA      (32'hdeadbeef)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dones();
        return {28'b0, bus.err_o, bus.c_load_done_o, bus.c_store_done_o, bus.a_ack_o};
    endfunction

    // Wait (bounded) for m_req_o, ack immediately, then check the DONE cycle.
    task automatic xact(input string tag, input logic [31:0] exp_addr,
                        input logic [31:0] rdata, input logic [31:0] exp_done);
        int unsigned n = 0;
        while (bus.m_req_o !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'b0, bus.m_req_o}, 32'd1);
        check({tag, "_addr"}, bus.m_addr_o, exp_addr);
        bus.m_ack_i  = 1'b1;
        bus.m_data_i = rdata;
        tick();
        bus.m_ack_i  = 1'b0;
        check({tag, "_done"}, dones(), exp_done);
        check({tag, "_reqdrop"}, {31'b0, bus.m_req_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.c_req_i = 0; bus.c_we_i = 0; bus.c_addr_i = '0; bus.c_data_s_i = '0; bus.c_bwe_i = '0;
        bus.a_req_i = 0; bus.a_we_i = 0; bus.a_addr_i = '0; bus.a_data_i = '0; bus.a_bwe_i = '0;
        bus.m_ack_i = 0; bus.m_data_i = '0;

        // Reset state
        do_reset();
        check("rst_mreq", {31'b0, bus.m_req_o}, 32'd0);
        check("rst_dones", dones(), 32'd0);
        check("rst_cdata", bus.c_data_l_o, 32'd0);
        check("rst_adata", bus.a_data_o, 32'd0);

        // Stray ack in IDLE is ignored
        bus.m_ack_i = 1'b1; bus.m_data_i = 32'h0bad0bad;
        tick();
        bus.m_ack_i = 1'b0;
        tick();
        check("idle_ack_dones", dones(), 32'd0);
        check("idle_ack_cdata", bus.c_data_l_o, 32'd0);

        // Core load, ack two cycles after m_req_o rises
        bus.c_req_i = 1; bus.c_we_i = 0; bus.c_addr_i = 32'h100; bus.c_bwe_i = 4'hf;
        tick();
        check("ld_req_c1", {31'b0, bus.m_req_o}, 32'd1);
        check("ld_addr", bus.m_addr_o, 32'h100);
        check("ld_we", {31'b0, bus.m_we_o}, 32'd0);
        tick();
        check("ld_req_c2", {31'b0, bus.m_req_o}, 32'd1);
        check("ld_nodone_c2", dones(), 32'd0);
        tick();
        check("ld_req_c3", {31'b0, bus.m_req_o}, 32'd1);
        bus.m_ack_i = 1'b1; bus.m_data_i = 32'h12345678;
        tick();
        bus.m_ack_i = 1'b0; bus.c_req_i = 0;
        check("ld_done", dones(), 32'b0100);
        check("ld_data", bus.c_data_l_o, 32'h12345678);
        check("ld_req_drop", {31'b0, bus.m_req_o}, 32'd0);
        tick();
        check("ld_single_pulse", dones(), 32'd0);
        check("ld_data_hold", bus.c_data_l_o, 32'h12345678);

        // Core store; store data changed mid-BUSY must not reach the bus
        bus.c_req_i = 1; bus.c_we_i = 1; bus.c_addr_i = 32'h200;
        bus.c_bwe_i = 4'b0011; bus.c_data_s_i = 32'haabbccdd;
        tick();
        check("st_we", {31'b0, bus.m_we_o}, 32'd1);
        check("st_bwe", {28'b0, bus.m_bwe_o}, 32'b0011);
        check("st_data", bus.m_data_o, 32'haabbccdd);
        bus.c_data_s_i = 32'h0; bus.c_addr_i = 32'h204; bus.c_bwe_i = 4'hf;
        tick();
        check("st_data_hold", bus.m_data_o, 32'haabbccdd);
        check("st_addr_hold", bus.m_addr_o, 32'h200);
        check("st_bwe_hold", {28'b0, bus.m_bwe_o}, 32'b0011);
        bus.m_ack_i = 1'b1;
        tick();
        bus.m_ack_i = 1'b0; bus.c_req_i = 0;
        check("st_done", dones(), 32'b0010);
        check("st_we_drop", {31'b0, bus.m_we_o}, 32'd0);
        check("st_ldata_kept", bus.c_data_l_o, 32'h12345678);
        tick();

        // Tie after reset: C, A, C, A with both requests held throughout
        do_reset();
        bus.c_req_i = 1; bus.c_we_i = 0; bus.c_addr_i = 32'h300;
        bus.a_req_i = 1; bus.a_we_i = 0; bus.a_addr_i = 32'h400; bus.a_bwe_i = 4'hf;
        xact("rr1_c", 32'h300, 32'h11, 32'b0100);
        check("rr1_cdata", bus.c_data_l_o, 32'h11);
        xact("rr2_a", 32'h400, 32'h22, 32'b0001);
        check("rr2_adata", bus.a_data_o, 32'h22);
        check("rr2_cdata_hold", bus.c_data_l_o, 32'h11);
        xact("rr3_c", 32'h300, 32'h33, 32'b0100);
        check("rr3_cdata", bus.c_data_l_o, 32'h33);
        xact("rr4_a", 32'h400, 32'h44, 32'b0001);
        check("rr4_adata", bus.a_data_o, 32'h44);
        check("rr4_cdata_hold", bus.c_data_l_o, 32'h33);
        bus.a_req_i = 0;

        // Back-to-back core loads: new address presented during DONE
        xact("b2b1", 32'h300, 32'h55, 32'b0100);
        bus.c_addr_i = 32'h104;
        tick();
        check("b2b_no_dup_grant", {31'b0, bus.m_req_o}, 32'd0);
        tick();
        check("b2b_req2", {31'b0, bus.m_req_o}, 32'd1);
        check("b2b_addr2", bus.m_addr_o, 32'h104);
        bus.m_ack_i = 1'b1; bus.m_data_i = 32'h66;
        tick();
        bus.m_ack_i = 1'b0; bus.c_req_i = 0;
        check("b2b_done2", dones(), 32'b0100);
        check("b2b_data2", bus.c_data_l_o, 32'h66);
        tick();

        // Reset while BUSY_A with ack pending
        bus.a_req_i = 1; bus.a_we_i = 0; bus.a_addr_i = 32'h500;
        tick();
        check("ra_busy", {31'b0, bus.m_req_o}, 32'd1);
        check("ra_addr", bus.m_addr_o, 32'h500);
        bus.m_ack_i = 1'b1; bus.m_data_i = 32'h77;
        #2 rst = 1'b1;
        #1;
        check("ra_async_drop", {31'b0, bus.m_req_o}, 32'd0);
        bus.a_req_i = 0;
        tick();
        rst = 1'b0;
        tick();
        check("ra_no_ack", dones(), 32'd0);
        check("ra_adata", bus.a_data_o, 32'd0);
        bus.m_ack_i = 1'b0;
        tick();
        check("ra_idle", {31'b0, bus.m_req_o}, 32'd0);
        bus.c_req_i = 1; bus.c_we_i = 0; bus.c_addr_i = 32'h108;
        xact("ra_after", 32'h108, 32'h88, 32'b0100);
        bus.c_req_i = 0;
        tick();

`ifdef RV_DM_TIMEOUT_EN
        // No ack: 16 BUSY cycles, then DONE with err_o and ERR_DATA
        bus.c_req_i = 1; bus.c_we_i = 0; bus.c_addr_i = 32'h600;
        tick();
        check("to_req", {31'b0, bus.m_req_o}, 32'd1);
        for (int i = 0; i < 15; i++) tick();
        check("to_req_last", {31'b0, bus.m_req_o}, 32'd1);
        check("to_no_err_yet", dones(), 32'd0);
        tick();
        bus.c_req_i = 0;
        check("to_done_err", dones(), 32'b1100);
        check("to_data", bus.c_data_l_o, 32'hdeadbeef);
        check("to_req_drop", {31'b0, bus.m_req_o}, 32'd0);
        tick();
        check("to_err_pulse", dones(), 32'd0);

        // Ack on the expiry cycle wins
        bus.c_req_i = 1; bus.c_addr_i = 32'h604;
        tick();
        for (int i = 0; i < 15; i++) tick();
        check("toa_req_last", {31'b0, bus.m_req_o}, 32'd1);
        bus.m_ack_i = 1'b1; bus.m_data_i = 32'hcafef00d;
        tick();
        bus.m_ack_i = 1'b0; bus.c_req_i = 0;
        check("toa_done", dones(), 32'b0100);
        check("toa_data", bus.c_data_l_o, 32'hcafef00d);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

endmodule
